// File: rtl/m72_sound_latch.sv
// Sound-CPU side of the main-to-sound command path: command queue, Z80 read/ack
// ports and the IM0 vector that merges the command and YM2151 interrupts.
module m72_sound_latch #(
  parameter int          DEPTH    = 1,
  parameter logic [7:0]  RD_PORT  = 8'h02,
  parameter logic [7:0]  ACK_PORT = 8'h06
) (
  input  logic       CLK_32M,
  input  logic       reset_n,
  input  logic       snd_wr,
  input  logic [7:0] snd_din,
  input  logic [7:0] z80_io_addr,
  input  logic       z80_io_wr,
  input  logic       z80_io_rd,
  output logic [7:0] z80_dout,
  output logic       z80_rd_hit,
  input  logic       ym_irq_n,
  output logic       z80_int_n,
  output logic [7:0] z80_int_vec,
  output logic       pending,
  output logic [7:0] overrun_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    overrun_q, overrun_d;
  logic          pending_q, ym_irq_q, snd_wr_q, ack_q;
  logic          ack_s, push_s, pop_s, full_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) return '0;
    else return p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    if (p == '0) return LAST_PTR;
    else return p - PW'(1);
  endfunction

  assign ack_s  = z80_io_wr && (z80_io_addr == ACK_PORT);
  assign push_s = snd_wr && !snd_wr_q;
  // A pop on an empty queue is dropped here, which also makes push+pop on empty land the push.
  assign pop_s  = ack_s && !ack_q && (count_q != '0);
  assign full_s = (count_q == FULL_CNT);

  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_s && full_s && !pop_s) begin
      // Full with no room being freed: replace the newest entry, keep the oldest ones.
      mem_d[ptr_dec(tail_q)] = snd_din;
      if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      else overrun_d = overrun_q;
    end else begin
      if (push_s) begin
        mem_d[tail_q] = snd_din;
        tail_d        = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) head_d = ptr_inc(head_q);
      else head_d = head_q;
      if (push_s && !pop_s) count_d = count_q + CW'(1);
      else if (!push_s && pop_s) count_d = count_q - CW'(1);
      else count_d = count_q;
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      overrun_q <= 8'h00;
      pending_q <= 1'b0;
      ym_irq_q  <= 1'b0;
      snd_wr_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      pending_q <= (count_d != '0);
      ym_irq_q  <= ~ym_irq_n;
      snd_wr_q  <= snd_wr;
      ack_q     <= ack_s;
    end
  end

  assign z80_dout    = mem_q[head_q];
  assign z80_rd_hit  = z80_io_rd && (z80_io_addr == RD_PORT);
  assign pending     = pending_q;
  assign overrun_cnt = overrun_q;
  assign z80_int_n   = ~(pending_q | ym_irq_q);
  // Bit 5 clear for a command, bit 4 clear for YM: FF/DF/EF/CF.
  assign z80_int_vec = {2'b11, ~pending_q, ~ym_irq_q, 4'hF};

endmodule

// File: tb/tb_m72_sound_latch.sv
// Directed bench: DUT a is the single-latch build (DEPTH=1), DUT b a 4-deep queue.
module tb_m72_sound_latch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_wr, a_iowr, a_iord, a_ym_n;
  logic [7:0] a_din, a_addr;
  logic [7:0] a_dout, a_vec, a_ovr;
  logic       a_hit, a_int_n, a_pend;
  logic       b_wr, b_iowr, b_iord, b_ym_n;
  logic [7:0] b_din, b_addr;
  logic [7:0] b_dout, b_vec, b_ovr;
  logic       b_hit, b_int_n, b_pend;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  m72_sound_latch #(.DEPTH(1)) dut_a (
    .CLK_32M(clk), .reset_n(reset_n), .snd_wr(a_wr), .snd_din(a_din),
    .z80_io_addr(a_addr), .z80_io_wr(a_iowr), .z80_io_rd(a_iord),
    .z80_dout(a_dout), .z80_rd_hit(a_hit), .ym_irq_n(a_ym_n),
    .z80_int_n(a_int_n), .z80_int_vec(a_vec), .pending(a_pend), .overrun_cnt(a_ovr)
  );

  m72_sound_latch #(.DEPTH(4)) dut_b (
    .CLK_32M(clk), .reset_n(reset_n), .snd_wr(b_wr), .snd_din(b_din),
    .z80_io_addr(b_addr), .z80_io_wr(b_iowr), .z80_io_rd(b_iord),
    .z80_dout(b_dout), .z80_rd_hit(b_hit), .ym_irq_n(b_ym_n),
    .z80_int_n(b_int_n), .z80_int_vec(b_vec), .pending(b_pend), .overrun_cnt(b_ovr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_din = d; a_wr = 1'b1; step(); a_wr = 1'b0; step();
  endtask

  task automatic ack_a();
    a_addr = 8'h06; a_iowr = 1'b1; step(); a_iowr = 1'b0; step();
  endtask

  task automatic push_b(input logic [7:0] d);
    b_din = d; b_wr = 1'b1; step(); b_wr = 1'b0; step();
  endtask

  task automatic ack_b();
    b_addr = 8'h06; b_iowr = 1'b1; step(); b_iowr = 1'b0; step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_wr = 1'b0; a_iowr = 1'b0; a_iord = 1'b0; a_ym_n = 1'b1; a_din = 8'h00; a_addr = 8'h00;
    b_wr = 1'b0; b_iowr = 1'b0; b_iord = 1'b0; b_ym_n = 1'b1; b_din = 8'h00; b_addr = 8'h00;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", a_pend); end
    checks++; if (a_int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n got %b want 1", a_int_n); end
    checks++; if (a_vec !== 8'hFF) begin errors++; $display("FAIL reset_vec got %h want ff", a_vec); end
    checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", a_dout); end
    checks++; if (b_ovr !== 8'h00) begin errors++; $display("FAIL reset_overrun got %h want 00", b_ovr); end
  endtask

  task automatic test_queue_read();
    a_din = 8'h3A; a_wr = 1'b1;
    step();
    checks++; if (a_int_n !== 1'b0) begin errors++; $display("FAIL qr_int_n got %b want 0", a_int_n); end
    checks++; if (a_vec !== 8'hDF) begin errors++; $display("FAIL qr_vec got %h want df", a_vec); end
    repeat (4) step();
    a_wr = 1'b0;
    step();
    checks++; if (a_ovr !== 8'h00) begin errors++; $display("FAIL qr_single_push overrun got %h want 00", a_ovr); end
    a_addr = 8'h02; a_iord = 1'b1; #1;
    checks++; if (a_hit !== 1'b1) begin errors++; $display("FAIL qr_rd_hit got %b want 1", a_hit); end
    checks++; if (a_dout !== 8'h3A) begin errors++; $display("FAIL qr_dout got %h want 3a", a_dout); end
    a_iord = 1'b0; #1;
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL qr_rd_hit_idle got %b want 0", a_hit); end
    step();
    a_addr = 8'h06; a_iowr = 1'b1;
    step();
    checks++; if (a_int_n !== 1'b1) begin errors++; $display("FAIL qr_ack_int_n got %b want 1", a_int_n); end
    checks++; if (a_vec !== 8'hFF) begin errors++; $display("FAIL qr_ack_vec got %h want ff", a_vec); end
    a_iowr = 1'b0;
    step();
  endtask

  task automatic test_ym_merge();
    push_a(8'h5C);
    a_ym_n = 1'b0;
    step();
    checks++; if (a_vec !== 8'hCF) begin errors++; $display("FAIL ym_both_vec got %h want cf", a_vec); end
    ack_a();
    checks++; if (a_vec !== 8'hEF) begin errors++; $display("FAIL ym_only_vec got %h want ef", a_vec); end
    checks++; if (a_int_n !== 1'b0) begin errors++; $display("FAIL ym_only_int_n got %b want 0", a_int_n); end
    a_ym_n = 1'b1;
    step();
    checks++; if (a_vec !== 8'hFF) begin errors++; $display("FAIL ym_clear_vec got %h want ff", a_vec); end
    checks++; if (a_int_n !== 1'b1) begin errors++; $display("FAIL ym_clear_int_n got %b want 1", a_int_n); end
  endtask

  task automatic test_overrun_depth1();
    push_a(8'h11);
    push_a(8'h22);
    checks++; if (a_dout !== 8'h22) begin errors++; $display("FAIL ovr1_dout got %h want 22", a_dout); end
    checks++; if (a_ovr !== 8'h01) begin errors++; $display("FAIL ovr1_count got %h want 01", a_ovr); end
    ack_a();
    checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL ovr1_ack_pending got %b want 0", a_pend); end
    checks++; if (a_int_n !== 1'b1) begin errors++; $display("FAIL ovr1_ack_int_n got %b want 1", a_int_n); end
  endtask

  task automatic test_empty_ack();
    ack_a();
    checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL empty_ack_pending got %b want 0", a_pend); end
    checks++; if (a_dout !== 8'h22) begin errors++; $display("FAIL empty_ack_dout got %h want 22", a_dout); end
    checks++; if (a_ovr !== 8'h01) begin errors++; $display("FAIL empty_ack_overrun got %h want 01", a_ovr); end
    // An underflowed count would leave the queue looking non-empty after the next push+ack.
    push_a(8'h66);
    ack_a();
    checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL empty_ack_underflow pending got %b want 0", a_pend); end
  endtask

  task automatic test_push_pop_same();
    push_a(8'h33);
    a_din = 8'h44; a_wr = 1'b1; a_addr = 8'h06; a_iowr = 1'b1;
    step();
    a_wr = 1'b0; a_iowr = 1'b0;
    step();
    checks++; if (a_pend !== 1'b1) begin errors++; $display("FAIL same_edge_pending got %b want 1", a_pend); end
    checks++; if (a_dout !== 8'h44) begin errors++; $display("FAIL same_edge_dout got %h want 44", a_dout); end
    checks++; if (a_int_n !== 1'b0) begin errors++; $display("FAIL same_edge_int_n got %b want 0", a_int_n); end
    checks++; if (a_ovr !== 8'h01) begin errors++; $display("FAIL same_edge_overrun got %h want 01", a_ovr); end
    ack_a();
    checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL same_edge_drain pending got %b want 0", a_pend); end
  endtask

  task automatic test_depth4_order();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h05;
    for (int i = 1; i <= 5; i++) push_b(8'(i));
    checks++; if (b_ovr !== 8'h01) begin errors++; $display("FAIL d4_overrun got %h want 01", b_ovr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_dout !== exp_q[i]) begin errors++; $display("FAIL d4_head%0d got %h want %h", i, b_dout, exp_q[i]); end
      checks++; if (b_vec !== 8'hDF) begin errors++; $display("FAIL d4_vec_before_ack%0d got %h want df", i, b_vec); end
      ack_b();
    end
    checks++; if (b_vec !== 8'hFF) begin errors++; $display("FAIL d4_vec_drained got %h want ff", b_vec); end
    checks++; if (b_int_n !== 1'b1) begin errors++; $display("FAIL d4_int_n_drained got %b want 1", b_int_n); end
  endtask

  task automatic test_async_reset();
    push_b(8'hA1);
    push_b(8'hA2);
    push_b(8'hA3);
    checks++; if (b_pend !== 1'b1) begin errors++; $display("FAIL ar_pre_pending got %b want 1", b_pend); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (b_pend !== 1'b0) begin errors++; $display("FAIL ar_pending got %b want 0", b_pend); end
    checks++; if (b_int_n !== 1'b1) begin errors++; $display("FAIL ar_int_n got %b want 1", b_int_n); end
    checks++; if (b_ovr !== 8'h00) begin errors++; $display("FAIL ar_overrun got %h want 00", b_ovr); end
    checks++; if (b_vec !== 8'hFF) begin errors++; $display("FAIL ar_vec got %h want ff", b_vec); end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (b_dout !== 8'h00) begin errors++; $display("FAIL ar_dout got %h want 00", b_dout); end
  endtask

  initial begin
    test_reset();
    test_queue_read();
    test_ym_merge();
    test_overrun_depth1();
    test_empty_ack();
    test_push_pop_same();
    test_depth4_order();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
